// File: rtl/llr_loader_if.sv
// rtl/llr_loader_if.sv - sample stream and cell write bus of the LLR loader
//
// Purpose: groups the channel-LLR valid/ready stream and the cell load bus
// (fsm_load, one-hot sin, broadcast din) into one bundle.
// Signals:
//   in_valid  sample present            in_ready  loader accepts this cycle
//   in_llr    signed channel LLR        fsm_load  load phase active
//   sin       one-hot cell write strobe din       saturated LLR to all cells
// Modports: slave = loader side, master = sample source / cell array side.
interface llr_loader_if #(
  parameter int D_WID  = 8,
  parameter int IN_WID = 12,
  parameter int N_CELL = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [IN_WID-1:0] in_llr;
  logic                     fsm_load;
  logic [N_CELL-1:0]        sin;
  logic signed [D_WID-1:0]  din;

  modport slave (
    input  in_valid, in_llr,
    output in_ready, fsm_load, sin, din
  );

  modport master (
    output in_valid, in_llr,
    input  in_ready, fsm_load, sin, din
  );
endinterface

// File: rtl/llr_loader.sv
// rtl/llr_loader.sv - saturating channel-LLR loader for the LDPC cell array
//
// Purpose: accepts one wide signed LLR per cell, clips it symmetrically to
// the cell width and writes it through a broadcast din plus one-hot sin
// strobe, then pulses done when the whole codeword is loaded.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       begin a frame load (IDLE only)
//   abort       cancel the load, highest priority
//   io          sample stream in, cell load bus out (llr_loader_if.slave)
//   busy        state != IDLE
//   done        one-cycle frame-complete pulse
//   sat_cnt     clipped samples in the current/last frame, sticks at 255
module llr_loader #(
  parameter int D_WID   = 8,
  parameter int IN_WID  = 12,
  parameter int N_CELL  = 16,
  parameter int IDX_WID = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  llr_loader_if.slave  io,
  output logic         busy,
  output logic         done,
  output logic [7:0]   sat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Symmetric clip range: the most negative code is never produced so the
  // decoder can negate any cell value without overflow.
  localparam int SAT_MAG = (1 << (D_WID - 1)) - 1;
  localparam logic signed [IN_WID-1:0] SAT_HI = IN_WID'(SAT_MAG);
  localparam logic signed [IN_WID-1:0] SAT_LO = IN_WID'(-SAT_MAG);
  localparam logic [IDX_WID-1:0] IDX_LAST = IDX_WID'(N_CELL - 1);

  state_t                  state_q, state_d;
  logic [IDX_WID-1:0]      idx_q, idx_d;
  logic [N_CELL-1:0]       sin_q, sin_d;
  logic signed [D_WID-1:0] din_q, din_d;
  logic                    fsm_load_q, fsm_load_d;
  logic                    done_q, done_d;
  logic [7:0]              sat_cnt_q, sat_cnt_d;

  logic                    in_ready;
  logic                    accept;
  logic                    clip_hi, clip_lo;
  logic signed [D_WID-1:0] sat_val;

  assign in_ready = (state_q == S_LOAD) & ~abort;
  assign accept   = io.in_valid & in_ready;

  always_comb begin
    clip_hi = io.in_llr > SAT_HI;
    clip_lo = io.in_llr < SAT_LO;
    sat_val = io.in_llr[D_WID-1:0];
    if (clip_hi) sat_val = SAT_HI[D_WID-1:0];
    if (clip_lo) sat_val = SAT_LO[D_WID-1:0];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sin_d      = '0;
    din_d      = din_q;
    fsm_load_d = fsm_load_q;
    done_d     = 1'b0;
    sat_cnt_d  = sat_cnt_q;

    if (abort) begin
      // Checked before the state decode so a simultaneous start cannot clear
      // the saturation count of the aborted frame.
      state_d    = S_IDLE;
      fsm_load_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_LOAD;
            idx_d      = '0;
            sat_cnt_d  = '0;
            fsm_load_d = 1'b1;
          end
        end
        S_LOAD: begin
          fsm_load_d = 1'b1;
          if (accept) begin
            din_d = sat_val;
            sin_d = N_CELL'(1) << idx_q;
            if ((clip_hi | clip_lo) && (sat_cnt_q != 8'hFF)) begin
              sat_cnt_d = sat_cnt_q + 8'd1;
            end
            if (idx_q == IDX_LAST) begin
              state_d = S_WAIT;
            end else begin
              idx_d = idx_q + IDX_WID'(1);
            end
          end
        end
        S_WAIT: begin
          // Final strobe is on sin this cycle; fsm_load drops with done.
          state_d    = S_DONE;
          done_d     = 1'b1;
          fsm_load_d = 1'b0;
        end
        S_DONE: begin
          state_d    = S_IDLE;
          fsm_load_d = 1'b0;
        end
        default: begin
          state_d    = S_IDLE;
          fsm_load_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sin_q      <= '0;
      din_q      <= '0;
      fsm_load_q <= 1'b0;
      done_q     <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sin_q      <= sin_d;
      din_q      <= din_d;
      fsm_load_q <= fsm_load_d;
      done_q     <= done_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign io.in_ready = in_ready;
  assign io.fsm_load = fsm_load_q;
  assign io.sin      = sin_q;
  assign io.din      = din_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_llr_loader.sv
// tb/tb_llr_loader.sv - scoreboard bench for llr_loader
module tb_llr_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, busy, done;
  logic [7:0] sat_cnt;
  logic       start2, abort2, busy2, done2;
  logic [7:0] sat_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int last_din = 0;

  logic [15:0] q_sin[$];
  int          q_din[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  llr_loader_if #(.D_WID(8), .IN_WID(12), .N_CELL(16)) bus ();
  llr_loader_if #(.D_WID(8), .IN_WID(12), .N_CELL(300)) bus2 ();

  llr_loader #(.D_WID(8), .IN_WID(12), .N_CELL(16), .IDX_WID(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .io(bus.slave), .busy(busy), .done(done), .sat_cnt(sat_cnt)
  );

  llr_loader #(.D_WID(8), .IN_WID(12), .N_CELL(300), .IDX_WID(9)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .io(bus2.slave), .busy(busy2), .done(done2), .sat_cnt(sat_cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int val, input int expv, input int idx);
    bus.in_valid = 1'b1;
    bus.in_llr   = 12'(val);
    q_sin.push_back(16'(1) << idx);
    q_din.push_back(expv);
    tick();
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 60; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    chk(name, done_cnt, target);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard monitor: each strobe pops the expectation pushed at issue time.
  always @(negedge clk) begin
    if (reset) begin
      last_din = 0;
    end else if (bus.sin != 16'd0) begin
      if (q_sin.size() == 0) begin
        chk("unexpected_strobe", int'(bus.sin), 0);
      end else begin
        logic [15:0] es;
        int ed;
        es = q_sin.pop_front();
        ed = q_din.pop_front();
        chk("sin", int'(bus.sin), int'(es));
        chk("din", int'(bus.din), ed);
        chk("sin_in_load", int'(bus.fsm_load), 1);
        last_din = ed;
      end
    end else begin
      chk("din_hold", int'(bus.din), last_din);
    end
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      chk("done_fsm_load_low", int'(bus.fsm_load), 0);
    end
  end

  int sat_in[5]  = '{300, -300, -128, 127, -127};
  int sat_exp[5] = '{127, -127, -127, 127, -127};
  int ab_in[5]   = '{200, 10, -500, 20, 30};
  int ab_exp[5]  = '{127, 10, -127, 20, 30};
  int dc;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_llr = '0;
    bus2.in_valid = 1'b0; bus2.in_llr = '0;

    @(negedge clk);
    chk("rst_sin", int'(bus.sin), 0);
    chk("rst_din", int'(bus.din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fsm_load", int'(bus.fsm_load), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    tick();
    reset = 1'b0;
    tick();

    // Full frame, continuous valid, start held through WAIT/DONE
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_llr = 12'(-50);
    q_sin.push_back(16'h0001);
    q_din.push_back(-50);
    @(negedge clk);
    chk("load_ready", int'(bus.in_ready), 1);
    chk("load_busy", int'(busy), 1);
    chk("load_fsm_load", int'(bus.fsm_load), 1);
    tick();
    for (int i = 1; i < 16; i++) feed(i * 7 - 50, i * 7 - 50, i);
    bus.in_valid = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("f1_done_count", done_cnt, 1);
    chk("f1_done_latency", done_cyc - start_cyc, 18);
    chk("f1_idle_after_done", int'(busy), 0);
    chk("f1_sat_cnt", int'(sat_cnt), 0);
    tick();
    @(negedge clk);
    chk("start_in_wait_ignored", int'(busy), 0);

    // Saturation
    tick();
    do_start();
    for (int i = 0; i < 5; i++) feed(sat_in[i], sat_exp[i], i);
    for (int i = 5; i < 16; i++) feed(0, 0, i);
    bus.in_valid = 1'b0;
    wait_done(2, "f2_done");
    chk("f2_sat_cnt", int'(sat_cnt), 3);

    // Bubbles: valid 1,0,0,...
    tick();
    tick();
    do_start();
    for (int i = 0; i < 16; i++) begin
      feed(60 - i * 8, 60 - i * 8, i);
      bus.in_valid = 1'b0;
      tick();
      tick();
    end
    wait_done(3, "f3_done");
    chk("f3_sat_cnt", int'(sat_cnt), 0);

    // Abort mid-frame with a sample presented
    tick();
    do_start();
    for (int i = 0; i < 5; i++) feed(ab_in[i], ab_exp[i], i);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_llr = 12'd99;
    @(negedge clk);
    chk("abort_ready_low", int'(bus.in_ready), 0);
    tick();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sin", int'(bus.sin), 0);
    chk("abort_fsm_load", int'(bus.fsm_load), 0);
    chk("abort_ready", int'(bus.in_ready), 0);
    chk("abort_din_hold", int'(bus.din), 30);
    chk("abort_sat_cnt", int'(sat_cnt), 2);
    dc = done_cnt;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    tick();
    do_start();
    for (int i = 0; i < 16; i++) feed(i, i, i);
    bus.in_valid = 1'b0;
    wait_done(dc + 1, "reload_done");
    chk("reload_sat_cnt", int'(sat_cnt), 0);

    // Asynchronous reset mid-LOAD
    tick();
    do_start();
    feed(400, 127, 0);
    feed(5, 5, 1);
    feed(6, 6, 2);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_sin", int'(bus.sin), 0);
    chk("arst_din", int'(bus.din), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_fsm_load", int'(bus.fsm_load), 0);
    chk("arst_ready", int'(bus.in_ready), 0);
    chk("arst_sat_cnt", int'(sat_cnt), 0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    chk("arst_stays_idle", int'(busy), 0);
    chk("queue_drained", q_sin.size(), 0);

    // sat_cnt ceiling with a 300-cell frame
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.in_llr = 12'd2000;
    for (int i = 0; i < 255; i++) tick();
    @(negedge clk);
    chk("ceil_at_255", int'(sat_cnt2), 255);
    for (int i = 255; i < 300; i++) tick();
    bus2.in_valid = 1'b0;
    @(negedge clk);
    chk("ceil_no_wrap", int'(sat_cnt2), 255);
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      if (done2) dc = 1;
      @(negedge clk);
    end
    chk("ceil_done", dc, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/llr_loader.md
# llr_loader

Front-end loader for the LDPC decoder's data-cell array. Accepts a stream of wide signed channel LLRs over a valid/ready handshake, saturates each to the cell data width, and writes one cell per accepted sample. Writes go out as a broadcast `din` bus plus a one-hot `sin` strobe vector, framed by the load-phase indicator `fsm_load`. It is the writer side of the cells' `sin`/`din` load port and signals frame completion to the decoder control FSM.

## Interface

Parameters:
- `D_WID`, 8: cell LLR width (signed).
- `IN_WID`, 12: channel LLR input width (signed); must be ≥ `D_WID`.
- `N_CELL`, 16: cells per codeword; one sample per cell per frame.
- `IDX_WID`, 4: index counter width; must satisfy ≥ clog2(`N_CELL`).

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begin a frame load. Honoured only in IDLE.
- `abort`, input, 1: cancel the load and return to IDLE. Highest priority.
- `in_valid`, input, 1: `in_llr` is valid.
- `in_ready`, output, 1: loader accepts a sample this cycle. Combinational: (state==LOAD) & !`abort`.
- `in_llr`, input, `IN_WID`: signed channel LLR.
- `fsm_load`, output, 1: load phase active. Drives the cells' `fsm[1]`.
- `sin`, output, `N_CELL`: one-hot write strobe; bit i writes cell i.
- `din`, output, `D_WID`: saturated LLR, broadcast to all cells.
- `busy`, output, 1: state != IDLE.
- `done`, output, 1: one-cycle pulse when a frame has loaded completely.
- `sat_cnt`, output, 8: number of saturated samples in the current/last frame.

## Operation

States: IDLE, LOAD, WAIT, DONE.
- IDLE → LOAD on `start`. On the same edge, `idx` and `sat_cnt` clear to 0.
- LOAD: on accept (`in_valid` & `in_ready`):
  - register `din` = sat(`in_llr`) and `sin` = 1<<`idx`;
  - if `idx` == `N_CELL`-1, go to WAIT; else `idx` increments.
  - Cycles without an accept: `sin` = 0; `din` holds its value.
- WAIT: `sin` shows the final strobe. `in_ready` = 0. Next state is DONE.
- DONE: `done` = 1 and `sin` = 0. Next state is IDLE.
- `abort` (any state): next state IDLE and `sin` cleared on the next edge. No `done` is generated. A sample presented in the abort cycle is not accepted. `sat_cnt` keeps its count.
- `start` outside IDLE is ignored. `start` and `abort` in the same cycle: abort wins.
- `fsm_load` = (state==LOAD) | (state==WAIT), registered with state. Every `sin` pulse therefore falls inside `fsm_load` high.

Saturation:
- Symmetric range ±(2^(`D_WID`-1)-1); for `D_WID`=8 this is -127..127. -128 is never produced.
- In-range inputs pass through unchanged (sign-truncated to `D_WID`).
- Any clipped sample increments `sat_cnt`. `sat_cnt` saturates at 255 and does not wrap.

Reset values: state IDLE, `idx` 0, `sin` 0, `din` 0, `fsm_load` 0, `done` 0, `sat_cnt` 0. `busy` and `in_ready` are 0 as derived outputs. Reset mid-frame discards the partial frame.

## Timing

- `start` at cycle t: LOAD, `in_ready`, `busy` and `fsm_load` are high from t+1.
- Accept at cycle a: `sin[idx]` high and `din` valid during a+1 only, i.e. one cycle of latency. Back-to-back accepts produce back-to-back strobes with no bubble.
- Last accept at a_L:
  - `sin[N_CELL-1]` at a_L+1 (WAIT);
  - `done` at a_L+2 with `fsm_load` low;
  - IDLE and `busy` low at a_L+3.
- Minimum time from `start` to `done` with a continuous stream: `N_CELL`+2 cycles.
- A new `start` is accepted from a_L+3.
- Abort at cycle b: all outputs are at reset-equivalent values from b+1, except `din` and `sat_cnt`, which hold.

## Test plan

- **Full frame, continuous valid**: `start`, then samples 0..15 each valid → `sin` walks 0x0001..0x8000 on consecutive cycles; `din` equals each sample; `done` arrives 18 cycles after `start`; `sat_cnt` = 0.
- **Saturation**: `in_llr` = 300, -300, -128, 127, -127 → `din` = 127, -127, -127, 127, -127; `sat_cnt` = 3.
- **Bubbles**: `in_valid` toggled 1,0,0,1,… → strobes appear only one cycle after each accept; `sin` is 0 in gap cycles; `din` holds; `idx` does not advance in gaps.
- **Abort mid-frame**: after 5 accepts, assert `abort` together with `in_valid` → sample not accepted; IDLE next cycle; `sin` = 0; no `done`; a following `start` reloads from cell 0.
- **Async reset mid-LOAD**: reset asserted between clock edges → all outputs go to reset values immediately; after release the block waits in IDLE; `start` during WAIT or DONE is ignored.
- **`sat_cnt` ceiling**: with `N_CELL`=300 and every sample out of range → `sat_cnt` stops at 255.
